ad7606_ctrl: RTL and testbench
==============================

// Module: ad7606_ctrl
// PURPOSE
//  Sequencer for one AD7606 8-channel ADC in parallel-read mode. Issues the power-up RESET
//  pulse, fires CONVST on request, tracks BUSY, then reads CH0..CH7 via CS/RD and emits one
//  tagged 16-bit sample per channel to the capture logic. Sits between the acquisition
//  trigger/config and the AD7606 pins (ad7606 model on the bench).
// PARAMETERS
//  RST_CYC        8      cycles ad_reset_o held high after reset_n_i release (>=50 ns)
//  CONVST_LO_CYC  4      cycles convst_o held low before its conversion-starting rising edge
//  RD_LO_CYC      4      cycles rd_o low per channel; db_i sampled on last low cycle (>=16 ns)
//  RD_HI_CYC      2      cycles rd_o high between channel reads
//  BUSY_HI_TO     16     max cycles from convst_o rise to synced busy high
//  BUSY_LO_TO     40000  max cycles busy may stay high (covers 315 us @ 100 MHz, OS x64)
// PORTS
//  clk_i           in   1   system clock (100 MHz nominal)
//  reset_n_i       in   1   asynchronous active-low reset
//  start_i         in   1   1-cycle pulse: start one conversion+readout frame
//  os_i            in   3   oversampling select, applied at next frame start
//  clr_err_i       in   1   clears err_o sticky bits
//  busy_i          in   1   AD7606 BUSY (async, 2-flop synchronised internally)
//  frstdata_i      in   1   AD7606 FRSTDATA
//  db_i            in   16  AD7606 data bus
//  ad_reset_o      out  1   AD7606 RESET, active high
//  convst_o        out  1   AD7606 CONVST A/B (tied), conversion on rising edge
//  cs_o, rd_o      out  1   AD7606 CS, RD, active low
//  os_o            out  3   AD7606 OS[2:0]
//  sample_o        out  16  captured sample
//  sample_chan_o   out  3   channel of sample_o
//  sample_valid_o  out  1   1-cycle strobe: sample_o/sample_chan_o valid
//  frame_done_o    out  1   1-cycle strobe after CH7 read completes
//  idle_o          out  1   high in S_IDLE only
//  err_o           out  3   sticky {frst_err, busy_timeout, overrun}
// BEHAVIOUR
//  Reset (async, any state): ad_reset_o=1, convst_o=1, cs_o=1, rd_o=1, os_o=0, sample_o=0,
//   sample_chan_o=0, strobes=0, idle_o=0, err_o=0, state=S_RESET. Frame in flight is dropped.
//  FSM:
//   S_RESET: ad_reset_o=1 for RST_CYC cycles after release, then 0 -> S_IDLE.
//   S_IDLE: idle_o=1. start_i=1 -> latch os_i into os_o (3'b111 saturates to 3'b110) -> S_CONV.
//   S_CONV: convst_o=0 for CONVST_LO_CYC cycles (first low cycle is the cycle after start_i),
//    then 1 -> S_WBH.
//   S_WBH: wait synced busy=1; after BUSY_HI_TO cycles without it set err_o[1] -> S_IDLE.
//   S_WBL: wait synced busy=0; after BUSY_LO_TO cycles set err_o[1] -> S_IDLE.
//   S_READ: cs_o=0 throughout; per channel n=0..7: rd_o=0 RD_LO_CYC cycles, capture db_i on last
//    low cycle, then rd_o=1 RD_HI_CYC cycles. Capture cycle+1: sample_o=db_i, sample_chan_o=n,
//    sample_valid_o=1. frstdata_i must be 1 at n=0 capture and 0 at n=1..7, else set err_o[2]
//    (sample still emitted). After CH7's RD_HI phase: cs_o=1, frame_done_o=1 -> S_IDLE.
//  start_i outside S_IDLE: ignored, err_o[0] set. start_i in S_IDLE same cycle as clr_err_i: both act.
//  err_o bits set-only until clr_err_i; set and clear in same cycle -> set wins.
//  os_o changes only on S_IDLE->S_CONV; os_i changes mid-frame have no effect on current frame.
//  Counters saturate, no wrap; timeout counters reload on every state entry.
//  Frame length (defaults, excl. conversion): 8*(4+2)=48 cycles with cs_o low.
// TESTING
//  1. Reset release -> ad_reset_o high exactly 8 cycles, idle_o=1 on cycle 9; convst/cs/rd all 1.
//  2. os_i=000, start_i -> convst_o low 4 cycles, busy ~4 us, 8 sample_valid strobes chan 0..7,
//     sample_o matches adcval.out words in order, frame_done_o once, err_o=0.
//  3. os_i=110 -> os_o=110, busy ~315 us completes without timeout; os_i=111 -> os_o=110.
//  4. busy_i forced 0 -> err_o=3'b010 after 16 cycles, back to idle; clr_err_i -> err_o=0.
//  5. start_i pulsed during S_READ -> err_o[0]=1, frame unaffected, no second conversion.
//  6. reset_n_i low mid-S_READ -> cs_o/rd_o=1 immediately, no frame_done_o; FSM restarts in S_RESET.

Source files
------------

// File: rtl/ad7606_ctrl.sv
// AD7606 parallel-read sequencer: power-up RESET pulse, CONVST on request,
// BUSY tracking, then CS/RD readout of CH0..CH7 as tagged 16-bit samples.
module ad7606_ctrl #(
  parameter int unsigned RST_CYC       = 8,
  parameter int unsigned CONVST_LO_CYC = 4,
  parameter int unsigned RD_LO_CYC     = 4,
  parameter int unsigned RD_HI_CYC     = 2,
  parameter int unsigned BUSY_HI_TO    = 16,
  parameter int unsigned BUSY_LO_TO    = 40000
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        start_i,
  input  logic [2:0]  os_i,
  input  logic        clr_err_i,
  input  logic        busy_i,
  input  logic        frstdata_i,
  input  logic [15:0] db_i,
  output logic        ad_reset_o,
  output logic        convst_o,
  output logic        cs_o,
  output logic        rd_o,
  output logic [2:0]  os_o,
  output logic [15:0] sample_o,
  output logic [2:0]  sample_chan_o,
  output logic        sample_valid_o,
  output logic        frame_done_o,
  output logic        idle_o,
  output logic [2:0]  err_o
);

  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] RST_LAST   = CW'(RST_CYC - 1);
  localparam logic [CW-1:0] CONV_LAST  = CW'(CONVST_LO_CYC - 1);
  localparam logic [CW-1:0] BHI_LAST   = CW'(BUSY_HI_TO - 1);
  localparam logic [CW-1:0] BLO_LAST   = CW'(BUSY_LO_TO - 1);
  localparam logic [CW-1:0] RDLO_LAST  = CW'(RD_LO_CYC - 1);
  localparam logic [CW-1:0] RD_LAST    = CW'(RD_LO_CYC + RD_HI_CYC - 1);

  typedef enum logic [2:0] {
    S_RESET, S_IDLE, S_CONV, S_WBH, S_WBL, S_READ
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    chan_q, chan_d;
  logic          busy_s1_q, busy_s2_q;
  logic          ad_reset_q, ad_reset_d;
  logic          convst_q, convst_d;
  logic          cs_q, cs_d;
  logic          rd_q, rd_d;
  logic [2:0]    os_q, os_d;
  logic [15:0]   sample_q, sample_d;
  logic [2:0]    sample_chan_q, sample_chan_d;
  logic          sample_valid_q, sample_valid_d;
  logic          frame_done_q, frame_done_d;
  logic          idle_q, idle_d;
  logic [2:0]    err_q, err_d;
  logic [2:0]    err_set;

  // Two-flop synchroniser for the asynchronous BUSY pin.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      busy_s1_q <= 1'b0;
      busy_s2_q <= 1'b0;
    end else begin
      busy_s1_q <= busy_i;
      busy_s2_q <= busy_s1_q;
    end
  end

  // State, counters and registered pin/strobe outputs.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q        <= S_RESET;
      cnt_q          <= '0;
      chan_q         <= '0;
      ad_reset_q     <= 1'b1;
      convst_q       <= 1'b1;
      cs_q           <= 1'b1;
      rd_q           <= 1'b1;
      os_q           <= '0;
      sample_q       <= '0;
      sample_chan_q  <= '0;
      sample_valid_q <= 1'b0;
      frame_done_q   <= 1'b0;
      idle_q         <= 1'b0;
      err_q          <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      chan_q         <= chan_d;
      ad_reset_q     <= ad_reset_d;
      convst_q       <= convst_d;
      cs_q           <= cs_d;
      rd_q           <= rd_d;
      os_q           <= os_d;
      sample_q       <= sample_d;
      sample_chan_q  <= sample_chan_d;
      sample_valid_q <= sample_valid_d;
      frame_done_q   <= frame_done_d;
      idle_q         <= idle_d;
      err_q          <= err_d;
    end
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead
  // so every pin comes straight from a flop.
  always_comb begin
    state_d        = state_q;
    cnt_d          = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    chan_d         = chan_q;
    ad_reset_d     = ad_reset_q;
    convst_d       = convst_q;
    cs_d           = cs_q;
    rd_d           = rd_q;
    os_d           = os_q;
    sample_d       = sample_q;
    sample_chan_d  = sample_chan_q;
    sample_valid_d = 1'b0;
    frame_done_d   = 1'b0;
    err_set        = '0;

    if (start_i && (state_q != S_IDLE)) err_set[0] = 1'b1;

    case (state_q)
      S_RESET: begin
        ad_reset_d = 1'b1;
        if (cnt_q == RST_LAST) begin
          ad_reset_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      S_IDLE: begin
        if (start_i) begin
          os_d     = (os_i == 3'b111) ? 3'b110 : os_i;
          convst_d = 1'b0;
          state_d  = S_CONV;
        end
      end
      S_CONV: begin
        if (cnt_q == CONV_LAST) begin
          convst_d = 1'b1;
          state_d  = S_WBH;
        end
      end
      S_WBH: begin
        if (busy_s2_q) begin
          state_d = S_WBL;
        end else if (cnt_q == BHI_LAST) begin
          err_set[1] = 1'b1;
          state_d    = S_IDLE;
        end
      end
      S_WBL: begin
        if (!busy_s2_q) begin
          cs_d    = 1'b0;
          rd_d    = 1'b0;
          chan_d  = '0;
          state_d = S_READ;
        end else if (cnt_q == BLO_LAST) begin
          err_set[1] = 1'b1;
          state_d    = S_IDLE;
        end
      end
      S_READ: begin
        // cnt_q is the position within one channel slot (RD low, then RD high).
        if (cnt_q == RDLO_LAST) begin
          rd_d           = 1'b1;
          sample_d       = db_i;
          sample_chan_d  = chan_q;
          sample_valid_d = 1'b1;
          if (frstdata_i != (chan_q == 3'd0)) err_set[2] = 1'b1;
        end else if (cnt_q == RD_LAST) begin
          if (chan_q == 3'd7) begin
            cs_d         = 1'b1;
            frame_done_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            chan_d = chan_q + 3'd1;
            rd_d   = 1'b0;
            cnt_d  = '0;
          end
        end
      end
      default: state_d = S_RESET;
    endcase

    if (state_d != state_q) cnt_d = '0;
    idle_d = (state_d == S_IDLE);
    err_d  = (clr_err_i ? 3'b000 : err_q) | err_set;
  end

  assign ad_reset_o     = ad_reset_q;
  assign convst_o       = convst_q;
  assign cs_o           = cs_q;
  assign rd_o           = rd_q;
  assign os_o           = os_q;
  assign sample_o       = sample_q;
  assign sample_chan_o  = sample_chan_q;
  assign sample_valid_o = sample_valid_q;
  assign frame_done_o   = frame_done_q;
  assign idle_o         = idle_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_ad7606_ctrl.sv
// Bench for ad7606_ctrl with a behavioural AD7606 model (BUSY timing by
// oversampling ratio, random channel words served on RD falling edges).
module tb_ad7606_ctrl;

  logic        clk = 1'b0;
  logic        reset_n_i, start_i, clr_err_i, busy_i, frstdata_i;
  logic [2:0]  os_i;
  logic [15:0] db_i;
  logic        ad_reset_o, convst_o, cs_o, rd_o, sample_valid_o, frame_done_o, idle_o;
  logic [2:0]  os_o, sample_chan_o, err_o;
  logic [15:0] sample_o;

  int tests = 0;
  int fails = 0;

  logic [15:0] words [8];
  bit          busy_dead = 1'b0;
  bit          frst_bad  = 1'b0;
  int          idx       = 0;

  task automatic chk(input string tag, input bit ok, input logic [31:0] obs,
                     input logic [31:0] expv);
    tests++;
    if (!ok) begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  always #5 clk = ~clk;

  ad7606_ctrl #(
    .RST_CYC(8), .CONVST_LO_CYC(4), .RD_LO_CYC(4), .RD_HI_CYC(2),
    .BUSY_HI_TO(16), .BUSY_LO_TO(40000)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n_i), .start_i(start_i), .os_i(os_i),
    .clr_err_i(clr_err_i), .busy_i(busy_i), .frstdata_i(frstdata_i), .db_i(db_i),
    .ad_reset_o(ad_reset_o), .convst_o(convst_o), .cs_o(cs_o), .rd_o(rd_o),
    .os_o(os_o), .sample_o(sample_o), .sample_chan_o(sample_chan_o),
    .sample_valid_o(sample_valid_o), .frame_done_o(frame_done_o),
    .idle_o(idle_o), .err_o(err_o)
  );

  // Conversion time in 100 MHz cycles for each oversampling ratio.
  function automatic int conv_cyc(input logic [2:0] os);
    case (os)
      3'd0:    return 400;
      3'd1:    return 950;
      3'd2:    return 1900;
      3'd3:    return 3900;
      3'd4:    return 7900;
      3'd5:    return 15800;
      default: return 31500;
    endcase
  endfunction

  // ADC conversion model: fresh random words at each CONVST rise, BUSY pulse.
  initial begin
    busy_i = 1'b0;
    forever begin
      @(negedge convst_o);
      @(posedge convst_o);
      for (int i = 0; i < 8; i++) words[i] = 16'($urandom);
      if (!busy_dead) begin
        repeat (3) @(posedge clk);
        busy_i = 1'b1;
        repeat (conv_cyc(os_o)) @(posedge clk);
        busy_i = 1'b0;
      end
    end
  end

  // ADC read model: each RD falling edge with CS low presents the next channel.
  initial begin
    db_i = '0;
    frstdata_i = 1'b0;
    forever begin
      @(negedge rd_o or posedge cs_o);
      #1;
      if (cs_o) idx = 0;
      else if (!rd_o) begin
        db_i       = words[idx % 8];
        frstdata_i = (idx == 0) ^ (frst_bad && idx == 0);
        idx++;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Called right after reset release on a falling clock edge.
  task automatic check_reset();
    int n;
    chk("rst_convst", convst_o === 1'b1, convst_o, 1'b1);
    chk("rst_cs", cs_o === 1'b1, cs_o, 1'b1);
    chk("rst_rd", rd_o === 1'b1, rd_o, 1'b1);
    chk("rst_idle", idle_o === 1'b0, idle_o, 1'b0);
    chk("rst_err", err_o === 3'b000, err_o, 3'b000);
    chk("rst_sample", sample_o === 16'h0000, sample_o, 16'h0000);
    n = 0;
    while (ad_reset_o === 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ad_reset_len", n === 8, n, 8);
    chk("idle_after_rst", idle_o === 1'b1, idle_o, 1'b1);
  endtask

  task automatic run_frame(input logic [2:0] os, input bit inject, input bit clr,
                           input logic [2:0] exp_err);
    int k, done, n;
    bit injected;
    logic [2:0] exp_os;
    exp_os = (os == 3'b111) ? 3'b110 : os;
    @(negedge clk);
    start_i = 1'b1; os_i = os; clr_err_i = clr;
    @(negedge clk);
    start_i = 1'b0; clr_err_i = 1'b0; os_i = 3'($urandom);
    chk("os_o", os_o === exp_os, os_o, exp_os);
    n = 0;
    while (convst_o === 1'b0 && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("convst_lo_cyc", n === 4, n, 4);
    k = 0; done = 0; n = 0; injected = 1'b0;
    while (idle_o !== 1'b1 && n < 45000) begin
      start_i = inject && (k == 3) && !injected;
      if (start_i) injected = 1'b1;
      if (sample_valid_o) begin
        chk("sample_chan", sample_chan_o === 3'(k), sample_chan_o, 3'(k));
        chk("sample_data", sample_o === words[k % 8], sample_o, words[k % 8]);
        k++;
      end
      if (frame_done_o) done++;
      @(negedge clk);
      n++;
    end
    start_i = 1'b0;
    if (frame_done_o) done++;
    chk("n_samples", k === 8, k, 8);
    chk("frame_done_cnt", done === 1, done, 1);
    chk("idle_end", idle_o === 1'b1, idle_o, 1'b1);
    chk("cs_end", cs_o === 1'b1, cs_o, 1'b1);
    chk("err_end", err_o === exp_err, err_o, exp_err);
    chk("os_hold", os_o === exp_os, os_o, exp_os);
    if (inject) begin
      n = 0;
      repeat (30) begin
        @(negedge clk);
        if (!convst_o || !idle_o) n++;
      end
      chk("no_reconv", n === 0, n, 0);
    end
  endtask

  initial begin
    int n, k;
    reset_n_i = 1'b0; start_i = 1'b0; clr_err_i = 1'b0; os_i = 3'b000;
    repeat (3) @(negedge clk);
    reset_n_i = 1'b1;
    check_reset();

    // Random-data frames at small oversampling ratios.
    run_frame(3'b000, 1'b0, 1'b0, 3'b000);
    for (int f = 0; f < 2; f++) run_frame(3'($urandom_range(0, 2)), 1'b0, 1'b0, 3'b000);

    // Longest conversion fits inside the BUSY-low timeout; OS 111 saturates.
    run_frame(3'b110, 1'b0, 1'b0, 3'b000);
    run_frame(3'b111, 1'b0, 1'b0, 3'b000);

    // BUSY never rises: timeout after 16 cycles, then clear.
    busy_dead = 1'b1;
    @(negedge clk); start_i = 1'b1; os_i = 3'b000;
    @(negedge clk); start_i = 1'b0;
    n = 0;
    while (convst_o !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    n = 0;
    while (err_o === 3'b000 && n < 100) begin @(negedge clk); n++; end
    chk("busy_to_cyc", n === 16, n, 16);
    chk("busy_to_err", err_o === 3'b010, err_o, 3'b010);
    chk("busy_to_idle", idle_o === 1'b1, idle_o, 1'b1);
    busy_dead = 1'b0;
    clr_err_i = 1'b1;
    @(negedge clk); clr_err_i = 1'b0;
    chk("clr_err", err_o === 3'b000, err_o, 3'b000);

    // Start during readout is flagged and ignored.
    run_frame(3'b000, 1'b1, 1'b0, 3'b001);
    // Clear together with start: error cleared and the frame still runs.
    run_frame(3'b001, 1'b0, 1'b1, 3'b000);

    // Wrong FRSTDATA on CH0: error flagged, samples still emitted.
    frst_bad = 1'b1;
    run_frame(3'b000, 1'b0, 1'b0, 3'b100);
    frst_bad = 1'b0;
    clr_err_i = 1'b1;
    @(negedge clk); clr_err_i = 1'b0;
    chk("clr_err_frst", err_o === 3'b000, err_o, 3'b000);

    // Asynchronous reset in the middle of readout.
    @(negedge clk); start_i = 1'b1; os_i = 3'b000;
    @(negedge clk); start_i = 1'b0;
    n = 0; k = 0;
    while (k < 2 && n < 2000) begin
      @(negedge clk);
      if (sample_valid_o) k++;
      n++;
    end
    chk("abort_reached_read", k === 2, k, 2);
    #2 reset_n_i = 1'b0;
    #1;
    chk("abort_cs", cs_o === 1'b1, cs_o, 1'b1);
    chk("abort_rd", rd_o === 1'b1, rd_o, 1'b1);
    chk("abort_ad_reset", ad_reset_o === 1'b1, ad_reset_o, 1'b1);
    chk("abort_done", frame_done_o === 1'b0, frame_done_o, 1'b0);
    chk("abort_idle", idle_o === 1'b0, idle_o, 1'b0);
    @(negedge clk);
    reset_n_i = 1'b1;
    check_reset();
    run_frame(3'b000, 1'b0, 1'b0, 3'b000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
